random_matrix_filler: RTL
=========================

# random_matrix_filler

Fills a rows×cols matrix with random elements for the matrix-calculator datapath. It sits directly downstream of `random_num_generator`: it drives that block's enable and range inputs, captures each random value it produces, and writes the values one per element into matrix storage through a simple write port. It signals completion with a one-cycle `done` pulse, and `err` on invalid dimensions.

## Interface
- `WIDTH`, 8: element/data width; must match generator `WIDTH`.
- `MAX_DIM`, 5: largest legal row/column count.
- `DIM_W`, 3: width of `rows`/`cols`; must hold `MAX_DIM`.
- `ADDR_W`, 5: linear address width; `2^ADDR_W >= MAX_DIM*MAX_DIM`.

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a fill; sampled only in IDLE.
- `rows`  in  DIM_W  row count, legal 1..MAX_DIM; latched on accepted start.
- `cols`  in  DIM_W  column count, legal 1..MAX_DIM; latched on accepted start.
- `min_in`  in  WIDTH  element minimum; latched on accepted start.
- `max_in`  in  WIDTH  element maximum; latched on accepted start.
- `rng_num`  in  WIDTH  random value from the generator.
- `rng_en`  out  1  generator enable, one-cycle pulse per element.
- `rng_min`  out  WIDTH  latched minimum, to generator `min_val`.
- `rng_max`  out  WIDTH  latched maximum, to generator `max_val`.
- `wr_en`  out  1  storage write strobe.
- `wr_addr`  out  ADDR_W  linear address, `row*cols + col`, row-major.
- `wr_row`, `wr_col`  out  DIM_W each  row/column index of the current write.
- `wr_data`  out  WIDTH  element value, equal to `rng_num` in the write cycle.
- `busy`  out  1  high from the cycle after an accepted start through the DONE cycle.
- `done`  out  1  one-cycle pulse at the end of a fill.
- `err`  out  1  one-cycle pulse, coincident with `done`, when dimensions were illegal.

## Operation
- FSM states: IDLE, GEN, WRITE, DONE.
- **IDLE:** on `start=1`, latch `rows`, `cols`, `min_in`, `max_in`.
  - If `rows` or `cols` is 0 or greater than `MAX_DIM`: set the error flag and go to DONE. No `rng_en` and no writes occur.
  - Otherwise clear `row`, `col` and `addr` to 0 and go to GEN.
- **GEN:** `rng_en=1` for exactly this cycle; go to WRITE.
- **WRITE:** `wr_en=1`, `wr_data=rng_num` (the generator has updated on the GEN edge). Then:
  - If `col == cols-1` and `row == rows-1`: go to DONE.
  - Otherwise, if `col == cols-1`: `col <= 0`, `row++`.
  - Otherwise: `col++`.
  - In both non-final cases: `addr++`, go to GEN.
- **DONE:** `done=1`, `err` equals the error flag; go to IDLE and clear the flag.
- `start` outside IDLE is ignored; there is no queuing.
- The range is passed through unchanged. When min > max, the generator's own fallback range applies; the filler still writes exactly `rows*cols` elements.
- Each element takes 2 cycles, so a full fill takes `2*rows*cols` cycles.
- Counter widths: `row`/`col` are DIM_W bits and `addr` is ADDR_W bits. They never wrap, because the bounds are checked at start.

## Timing
- **Reset values:** state IDLE; all outputs 0, including `rng_min`, `rng_max`, `wr_addr`, `wr_row`, `wr_col` and `wr_data`; internal latches 0.
- **Start accepted at edge 0:**
  - GEN in cycle 1.
  - First write in cycle 2.
  - Write for element i in cycle `2+2i`.
  - `done` in cycle `2*rows*cols + 1`.
  - `busy` high in cycles 1 through the `done` cycle.
- A new `start` can be accepted in the cycle after `done` (IDLE).
- **Error path:** `done` and `err` are both high in cycle 1; `busy` is high in cycle 1 only.
- `rng_min`/`rng_max` are stable from cycle 1 until the next accepted start.
- **Reset mid-fill:** outputs clear immediately. No further writes occur and no `done` is issued. The generator is reset by the same `rst_n`.
- All outputs are registered or decoded from registered state only; there are no combinational paths from `start` to any output.

## Structure
- Shared package: FSM state encoding (IDLE/GEN/WRITE/DONE) and the `MAX_DIM`/`DIM_W` constants, which the matrix storage and display blocks also use.
- No sub-module is needed inside; `random_num_generator` is instantiated alongside at the parent level.
- The bench instantiates both blocks and a 25-entry array for storage.

## Test plan
- **Normal 2×3 fill:** rows=2, cols=3, min=1, max=9, start → six writes at addresses 0..5, row/col (0,0)…(1,2), all `wr_data` in 1..9 and equal to `rng_num`; `done` in cycle 13; `err=0`.
- **Illegal dimensions:** rows=0, cols=3, start → `done=err=1` in cycle 1; zero `wr_en` and zero `rng_en`. Repeat with rows=6, same result.
- **Maximum size with degenerate range:** 5×5 with min=max=7 → 25 writes, all data=7, last address 24; `done` in cycle 51.
- **Reversed range:** min=200, max=10, 1×1 → exactly one write with any 8-bit value; `rng_min=200`, `rng_max=10` held.
- **Start while busy:** pulse `start` with rows=1 in cycle 4 of a 2×2 fill → ignored; four writes occur and the latched dimensions are unchanged.
- **Reset mid-fill:** assert `rst_n=0` after the third write of a 3×3 fill → all outputs 0 asynchronously; no `done`. Then start a 1×2 fill → two writes at addresses 0 and 1, with `done` in cycle 5.

Source files
------------

// File: rtl/random_matrix_filler_pkg.sv
// Shared constants and FSM encoding for the matrix filler and its neighbours.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package random_matrix_filler_pkg;

  // Largest legal row/column count and the index width that holds it.
  localparam int MAX_DIM = 5;
  localparam int DIM_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_e;

endpackage

// File: rtl/random_matrix_filler_if.sv
// Control, generator and storage-write signals of the matrix filler.
// Latency: n/a (wiring only).
// Backpressure: none; storage accepts every write strobe.
interface random_matrix_filler_if #(
  parameter int WIDTH  = 8,
  parameter int DIM_W  = 3,
  parameter int ADDR_W = 5
);

  logic              start;
  logic [DIM_W-1:0]  rows;
  logic [DIM_W-1:0]  cols;
  logic [WIDTH-1:0]  min_in;
  logic [WIDTH-1:0]  max_in;
  logic [WIDTH-1:0]  rng_num;
  logic              rng_en;
  logic [WIDTH-1:0]  rng_min;
  logic [WIDTH-1:0]  rng_max;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DIM_W-1:0]  wr_row;
  logic [DIM_W-1:0]  wr_col;
  logic [WIDTH-1:0]  wr_data;
  logic              busy;
  logic              done;
  logic              err;

  // Requester / generator / storage side.
  modport master (
    output start, rows, cols, min_in, max_in, rng_num,
    input  rng_en, rng_min, rng_max, wr_en, wr_addr, wr_row, wr_col,
           wr_data, busy, done, err
  );

  // Filler side.
  modport slave (
    input  start, rows, cols, min_in, max_in, rng_num,
    output rng_en, rng_min, rng_max, wr_en, wr_addr, wr_row, wr_col,
           wr_data, busy, done, err
  );

endinterface

// File: rtl/random_matrix_filler.sv
// Fills a rows x cols matrix, one generator pulse then one write per element.
// Latency: 2 cycles per element, done pulse at cycle 2*rows*cols+1 (cycle 1 on error).
// Backpressure: none; start is ignored unless idle, storage must accept every write.
module random_matrix_filler #(
  parameter int WIDTH   = 8,
  parameter int MAX_DIM = 5,
  parameter int DIM_W   = 3,
  parameter int ADDR_W  = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  random_matrix_filler_if.slave  bus
);
  import random_matrix_filler_pkg::*;

  localparam logic [DIM_W-1:0]  MAX_D    = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0]  ONE_D    = DIM_W'(1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  fill_state_e       state;
  logic [DIM_W-1:0]  rows_q;
  logic [DIM_W-1:0]  cols_q;
  logic [DIM_W-1:0]  row_q;
  logic [DIM_W-1:0]  col_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  rng_min_q;
  logic [WIDTH-1:0]  rng_max_q;
  logic              err_flag;
  logic              rng_en_q;
  logic              wr_en_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              last_col;
  logic              last_row;
  logic              dims_bad;

  // Dimensions were range-checked at start, so cols_q/rows_q are never 0 here.
  assign last_col = (col_q == cols_q - ONE_D);
  assign last_row = (row_q == rows_q - ONE_D);
  assign dims_bad = (bus.rows == '0) || (bus.rows > MAX_D) ||
                    (bus.cols == '0) || (bus.cols > MAX_D);

  // Sequencer: accept start, alternate GEN/WRITE per element, pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rows_q    <= '0;
      cols_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      addr_q    <= '0;
      rng_min_q <= '0;
      rng_max_q <= '0;
      err_flag  <= 1'b0;
      rng_en_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            rows_q    <= bus.rows;
            cols_q    <= bus.cols;
            rng_min_q <= bus.min_in;
            rng_max_q <= bus.max_in;
            busy_q    <= 1'b1;
            if (dims_bad) begin
              // Skip straight to completion: no generator pulses, no writes.
              err_flag <= 1'b1;
              done_q   <= 1'b1;
              err_q    <= 1'b1;
              state    <= ST_DONE;
            end else begin
              row_q    <= '0;
              col_q    <= '0;
              addr_q   <= '0;
              rng_en_q <= 1'b1;
              state    <= ST_GEN;
            end
          end
        end
        ST_GEN: begin
          rng_en_q <= 1'b0;
          wr_en_q  <= 1'b1;
          state    <= ST_WRITE;
        end
        ST_WRITE: begin
          wr_en_q <= 1'b0;
          if (last_col && last_row) begin
            done_q <= 1'b1;
            err_q  <= err_flag;
            state  <= ST_DONE;
          end else begin
            if (last_col) begin
              col_q <= '0;
              row_q <= row_q + ONE_D;
            end else begin
              col_q <= col_q + ONE_D;
            end
            addr_q   <= addr_q + ONE_A;
            rng_en_q <= 1'b1;
            state    <= ST_GEN;
          end
        end
        ST_DONE: begin
          done_q   <= 1'b0;
          err_q    <= 1'b0;
          busy_q   <= 1'b0;
          err_flag <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rng_en  = rng_en_q;
  assign bus.rng_min = rng_min_q;
  assign bus.rng_max = rng_max_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = addr_q;
  assign bus.wr_row  = row_q;
  assign bus.wr_col  = col_q;
  // Generator output settles on the GEN edge, so pass it through in the write cycle only.
  assign bus.wr_data = wr_en_q ? bus.rng_num : '0;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule
